dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder that sits on the far side of the MEM stage's load/store port, answering the pipeline's memory requests.
- Accepts one request at a time over a valid/ready request channel.
- Inserts a programmable number of wait states, then returns read data or a write acknowledgement over a valid/ready response channel.
- Byte-lane write strobes match the pipeline's 8-bit write-width mask; out-of-range accesses complete with an error flag and no side effect.

Parameters:
- DATA_W, 64, data bus width in bits; fixed at 64 (8 byte lanes).
- ADDR_W, 64, request address width.
- DEPTH, 4096, storage depth in 64-bit words (power of two).
- BASE_ADDR, 64'h8000_0000, byte address of word 0.
- WAIT_CYCLES, 1, wait states between acceptance and response (0..15).

Ports:
- sys_clk  in  1  clock, all state on rising edge.
- sys_rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address; bits [2:0] ignored (word aligned).
- req_wdata  in  DATA_W  store data.
- req_wstrb  in  8  byte-lane enables; bit i writes bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  address outside [BASE_ADDR, BASE_ADDR+DEPTH*8).

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (sys_rst low, asynchronous): state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - Storage contents are not reset.
  - A request accepted but not yet committed when reset asserts is dropped; no write occurs.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch we, addr, wdata, wstrb.
  - Go to WAIT with counter = WAIT_CYCLES-1 if WAIT_CYCLES > 0; otherwise go directly to RESP.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle; at 0, go to RESP.
- Entry into RESP (the edge that sets rsp_valid): the access is performed exactly once.
  - Word index = (addr - BASE_ADDR) >> 3.
  - In range, load: rsp_rdata = mem[index], rsp_err = 0.
  - In range, store: lanes with wstrb[i] = 1 are updated; other lanes keep their value. rsp_rdata = 0, rsp_err = 0.
  - Store with wstrb = 0: no change, normal response.
  - Out of range: no write, rsp_rdata = 0, rsp_err = 1.
- RESP:
  - rsp_valid = 1, req_ready = 0.
  - rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready.
  - On handshake, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err on the same edge.
  - Back-to-back: the next request can be accepted the cycle after the handshake (req_ready rises in IDLE).
- Latency: request handshake at cycle T gives rsp_valid at T+1+WAIT_CYCLES with rsp_ready held high. Throughput: one access per WAIT_CYCLES+2 cycles.
- Load after store to the same word always returns the updated data (single outstanding request, so no hazard).
- req_valid asserted outside IDLE is ignored; the requester must hold it until req_ready.
- Address arithmetic is unsigned ADDR_W-bit.
  - addr < BASE_ADDR is out of range; no wrap-around into storage.
  - The last in-range byte is BASE_ADDR+DEPTH*8-1; the next word errors.

Test Plan:
- Reset then WAIT_CYCLES=1 -> req_ready=1, rsp_valid=0. Store addr 0x8000_0010, wdata 0x1122334455667788, wstrb 0xFF, rsp_ready=1 -> rsp_valid at cycle T+2, rsp_err=0, rsp_rdata=0.
- Load 0x8000_0010 -> rsp_rdata = 0x1122334455667788. Then store wdata 0xAAAA..AA with wstrb 0x0F, then load -> 0x11223344AAAAAAAA.
- Load 0x7FFF_FFF8 and load 0x8000_0000+DEPTH*8 -> rsp_err=1, rsp_rdata=0. Then load the last word 0x8000_0000+DEPTH*8-8 -> rsp_err=0.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable, req_ready=0, and a req_valid pulse meanwhile is not accepted. Raise rsp_ready -> IDLE next cycle.
- Pulse sys_rst low asynchronously during WAIT of a store to 0x8000_0020 (prior data 0x0) -> outputs return to reset values immediately. A subsequent load of 0x8000_0020 returns 0x0.
- WAIT_CYCLES=0: ten back-to-back loads with rsp_ready=1 -> each response arrives 1 cycle after acceptance, one access every 2 cycles, data matches a reference model.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the MEM stage load/store port. It takes one request
// at a time, waits WAIT_CYCLES cycles, performs the access once and then presents
// the response until the requester takes it.
//
// Handshake semantics (both channels): a transfer happens on the rising edge of
// sys_clk where valid and ready are both high. The requester keeps req_valid and
// the request fields stable until req_ready. The responder keeps rsp_valid,
// rsp_rdata and rsp_err stable until rsp_ready.
//
// Ports:
//   sys_clk    clock, all state on the rising edge
//   sys_rst    asynchronous active-low reset
//   req_valid  request present            req_ready  responder can accept
//   req_we     1 = store, 0 = load        req_addr   byte address ([2:0] ignored)
//   req_wdata  store data                 req_wstrb  byte-lane write enables
//   rsp_valid  response present           rsp_ready  requester accepts response
//   rsp_rdata  load data (0 for stores and errors)
//   rsp_err    address outside [BASE_ADDR, BASE_ADDR + DEPTH*8)
//   dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int                DATA_W      = 64,
    parameter int                ADDR_W      = 64,
    parameter int                DEPTH       = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(64'h8000_0000),
    parameter int                WAIT_CYCLES = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [7:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);

    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH) << 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [7:0]          wstrb_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                accept;
    logic                enter_resp;
    logic                do_write;

    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [7:0]          acc_wstrb;
    logic [ADDR_W-1:0]   off;
    logic                in_range;
    logic [IDX_W-1:0]    idx;

    logic [DATA_W-1:0]   mem [DEPTH];

    // With zero wait states the access happens on the acceptance edge itself, so
    // it must use the live request rather than the (not yet loaded) latches.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wstrb = wstrb_q;
        if (state_q == S_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end
    end

    // Range check on the unsigned offset: addresses below BASE_ADDR wrap to a
    // huge offset, and the explicit lower-bound compare keeps them out anyway.
    always_comb begin
        off      = acc_addr - BASE_ADDR;
        in_range = (acc_addr >= BASE_ADDR) && (off < SPAN);
        idx      = off[IDX_W+2:3];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The access is performed on exactly one edge: the one entering RESP.
        if (enter_resp) begin
            if (!in_range) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end else if (acc_we) begin
                rdata_d = '0;
                err_d   = 1'b0;
            end else begin
                rdata_d = mem[idx];
                err_d   = 1'b0;
            end
        end
    end

    assign do_write = enter_resp && in_range && acc_we;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
        end
    end

    // Storage is deliberately not reset. A reset during WAIT returns the FSM to
    // IDLE before RESP is entered, so the dropped store never reaches here.
    always_ff @(posedge sys_clk) begin
        if (do_write) begin
            for (int i = 0; i < 8; i++) begin
                if (acc_wstrb[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign dbg_state = state_q;

endmodule
